// File: rtl/nano_mem_arbiter.sv
// Single-port RAM arbiter for nano_riscv fetch (IF) and load/store (D) ports.
// Optional starvation guard for fetches is enabled by defining ARB_STARVE_GUARD_EN.
module nano_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [3:0]        i_d_be,
  input  logic [31:0]       i_d_addr,
  input  logic [31:0]       i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [31:0]       o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_busy
);

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_IF   = 2'd1;
  localparam logic [1:0] SEL_D    = 2'd2;

  logic [1:0]  resp_sel;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        force_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign force_if = (starve_cnt == CNT_W'(STARVE_MAX));

  // Counts consecutive denied fetch cycles; saturates so IF keeps winning until granted.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_if_req || o_if_gnt) begin
      starve_cnt <= '0;
    end else if (!force_if) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  assign o_if_gnt = !i_rst && i_if_req && (!i_d_req || force_if);
  assign o_d_gnt  = !i_rst && i_d_req && !o_if_gnt;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = 4'b0000;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (o_if_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_be   = 4'b1111;
      o_mem_addr = i_if_addr[ADDR_W+1:2];
    end else if (o_d_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_we   = i_d_we;
      o_mem_be   = i_d_we ? i_d_be : 4'b1111;
      o_mem_addr = i_d_addr[ADDR_W+1:2];
      if (i_d_we) begin
        o_mem_wdata = i_d_wdata;
      end
    end
  end

  // Ignored address bits: byte offset and high-order aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_if_addr[31:ADDR_W+2], i_if_addr[1:0],
                              i_d_addr[31:ADDR_W+2], i_d_addr[1:0]};

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      resp_sel <= SEL_NONE;
    end else if (o_if_gnt) begin
      resp_sel <= SEL_IF;
    end else if (o_d_gnt && !i_d_we) begin
      resp_sel <= SEL_D;
    end else begin
      resp_sel <= SEL_NONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (resp_sel == SEL_IF) if_rdata_q <= i_mem_rdata;
      if (resp_sel == SEL_D)  d_rdata_q  <= i_mem_rdata;
    end
  end

  // RAM data arrives in the cycle after the grant; pass it straight through, then hold it.
  assign o_if_rvalid = (resp_sel == SEL_IF) && !i_rst;
  assign o_d_rvalid  = (resp_sel == SEL_D) && !i_rst;
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : if_rdata_q;
  assign o_d_rdata   = o_d_rvalid ? i_mem_rdata : d_rdata_q;
  assign o_busy      = (resp_sel != SEL_NONE);

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Scoreboard bench for nano_mem_arbiter: directed vectors push expected read responses,
// a negedge monitor pops and checks them. Guard expectations follow ARB_STARVE_GUARD_EN.
module tb_nano_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  nano_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM with byte enables.
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_rd(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  // Response monitor: decoupled from stimulus, checks port, data and timing.
  always @(negedge clk) begin
    exp_t e;
    check("rvalid_exclusive", {31'd0, if_rvalid & d_rvalid}, 32'd0);
    if (if_rvalid || d_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: if_rvalid=%0b d_rvalid=%0b with nothing pending", if_rvalid, d_rvalid);
      end else begin
        e = sb.pop_front();
        check("resp_port_is_d", {31'd0, d_rvalid}, {31'd0, e.is_d});
        check("resp_data", e.is_d ? d_rdata : if_rdata, e.data);
        check("resp_cycle", cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_rvalid: no response in cycle %0d, expected 0x%08h", cyc, e.data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_if(input logic req, input logic [31:0] addr);
    if_req  = req;
    if_addr = addr;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    d_req   = req;
    d_we    = we;
    d_be    = be;
    d_addr  = addr;
    d_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit guard_on;
    logic exp_if;
`ifdef ARB_STARVE_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif
    for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = 32'h0;
    ram[0] = 32'hDEADBEEF;
    ram[2] = 32'h00A00093;
    ram[4] = 32'h11223344;
    ram[8] = 32'hCAFEF00D;

    // Requests present during reset must not be granted nor write the RAM.
    rst = 1'b1;
    set_if(1'b1, 32'h8);
    set_d(1'b1, 1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF);
    tick(); mid();
    check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    tick();

    rst = 1'b0;
    set_if(1'b0, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mid();
    check("reset_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("reset_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("reset_if_rdata", if_rdata, 32'd0);
    check("reset_d_rdata", d_rdata, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("idle_mem_en", {31'd0, mem_en}, 32'd0);
    check("idle_mem_addr", {22'd0, mem_addr}, 32'd0);

    // Single fetch.
    tick(); set_if(1'b1, 32'h8); mid();
    check("fetch_if_gnt", {31'd0, if_gnt}, 32'd1);
    check("fetch_d_gnt", {31'd0, d_gnt}, 32'd0);
    check("fetch_mem_addr", {22'd0, mem_addr}, 32'd2);
    check("fetch_mem_we", {31'd0, mem_we}, 32'd0);
    check("fetch_mem_be", {28'd0, mem_be}, 32'hF);
    expect_rd(1'b0, 32'h00A00093);
    tick(); set_if(1'b0, 32'h0); mid();
    check("fetch_busy", {31'd0, busy}, 32'd1);
    check("idle2_mem_en", {31'd0, mem_en}, 32'd0);

    // Byte store then load of the same word.
    tick(); set_d(1'b1, 1'b1, 4'b1000, 32'h13, 32'hAB00_0000); mid();
    check("store_d_gnt", {31'd0, d_gnt}, 32'd1);
    check("store_mem_addr", {22'd0, mem_addr}, 32'd4);
    check("store_mem_we", {31'd0, mem_we}, 32'd1);
    check("store_mem_be", {28'd0, mem_be}, 32'h8);
    check("store_mem_wdata", mem_wdata, 32'hAB00_0000);
    tick(); set_d(1'b1, 1'b0, 4'b0000, 32'h10, 32'h0); mid();
    check("store_no_busy", {31'd0, busy}, 32'd0);
    check("load_mem_be", {28'd0, mem_be}, 32'hF);
    check("load_mem_we", {31'd0, mem_we}, 32'd0);
    expect_rd(1'b1, 32'hAB22_3344);

    // Store with no byte enables is granted but changes nothing.
    tick(); set_d(1'b1, 1'b1, 4'b0000, 32'h10, 32'h0); mid();
    check("be0_d_gnt", {31'd0, d_gnt}, 32'd1);
    check("be0_mem_en", {31'd0, mem_en}, 32'd1);
    check("be0_mem_we", {31'd0, mem_we}, 32'd1);
    check("be0_mem_be", {28'd0, mem_be}, 32'h0);
    tick(); set_d(1'b1, 1'b0, 4'b0000, 32'h10, 32'h0); mid();
    expect_rd(1'b1, 32'hAB22_3344);

    // Collision: D wins, IF follows alone next cycle.
    tick(); set_if(1'b1, 32'h8); set_d(1'b1, 1'b0, 4'b0000, 32'h20, 32'h0); mid();
    check("coll_d_gnt", {31'd0, d_gnt}, 32'd1);
    check("coll_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("coll_mem_addr", {22'd0, mem_addr}, 32'd8);
    expect_rd(1'b1, 32'hCAFE_F00D);
    tick(); set_d(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); mid();
    check("coll2_if_gnt", {31'd0, if_gnt}, 32'd1);
    check("coll2_mem_addr", {22'd0, mem_addr}, 32'd2);
    expect_rd(1'b0, 32'h00A00093);
    tick(); set_if(1'b0, 32'h0); mid();

    // Aliased back-to-back loads.
    tick(); set_d(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0); mid();
    check("alias0_mem_addr", {22'd0, mem_addr}, 32'd0);
    expect_rd(1'b1, 32'hDEAD_BEEF);
    tick(); set_d(1'b1, 1'b0, 4'b0000, 32'h1000, 32'h0); mid();
    check("alias1_d_gnt", {31'd0, d_gnt}, 32'd1);
    check("alias1_mem_addr", {22'd0, mem_addr}, 32'd0);
    expect_rd(1'b1, 32'hDEAD_BEEF);
    tick(); set_d(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); mid();

    // Reset in the cycle after a load grant suppresses its response.
    tick(); set_d(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0); mid();
    check("rstrd_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick(); rst = 1'b1; set_d(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); mid();
    check("rstrd_c1_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    tick(); rst = 1'b0; mid();
    check("rstrd_c2_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("rstrd_c2_d_rdata", d_rdata, 32'd0);
    check("rstrd_c2_if_rdata", if_rdata, 32'd0);
    check("rstrd_c2_busy", {31'd0, busy}, 32'd0);

    // Continuous D and IF traffic: guard grants IF every (STARVE_MAX+1)th cycle.
    for (int k = 1; k <= 20; k++) begin
      tick();
      set_if(1'b1, 32'h8);
      set_d(1'b1, 1'b0, 4'b0000, 32'h20, 32'h0);
      mid();
      exp_if = guard_on && (k % (STARVE_MAX + 1) == 0);
      check($sformatf("starve_if_gnt_%0d", k), {31'd0, if_gnt}, {31'd0, exp_if});
      check($sformatf("starve_d_gnt_%0d", k), {31'd0, d_gnt}, {31'd0, !exp_if});
      if (exp_if) expect_rd(1'b0, 32'h00A00093);
      else        expect_rd(1'b1, 32'hCAFE_F00D);
    end
    tick();
    set_if(1'b0, 32'h0);
    set_d(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    mid();
    tick(); mid();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
